ps2_mouse_device: RTL

Device-side PS/2 mouse: the far end of the host link that MouseDriverIO drives over CLK_MOUSE/DATA_MOUSE.
- Generates the PS/2 clock and transmits 3-byte movement packets.
- Receives and acknowledges host commands and sends the standard response bytes.
- Serves as the bench/board-loopback counterpart for MouseDriverIO, and as a synthesisable emulator driven by on-board stimulus.

---
 rtl/ps2_dev_pkg.sv | 22 ++
 rtl/ps2_dev_phy.sv | 162 ++++++++++++++++
 rtl/ps2_mouse_device.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ps2_dev_pkg.sv
// Shared constants and FSM encoding for the device-side PS/2 mouse.
// No logic; latency and backpressure are properties of the modules that import it.
package ps2_dev_pkg;

    localparam logic [7:0] ACK         = 8'hFA;
    localparam logic [7:0] BAT_OK      = 8'hAA;
    localparam logic [7:0] DEV_ID      = 8'h00;
    localparam logic [7:0] RESEND      = 8'hFE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_DISABLE = 8'hF5;
    localparam logic [7:0] CMD_GET_ID  = 8'hF2;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, TX_HIGH, TX_LOW, TX_GAP, RX_HIGH, RX_LOW, RX_ACK
    } state_t;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_dev_phy.sv
// PS/2 bit engine: clock generation, 11-bit TX/RX framing, parity, host-abort detection.
// One byte per tx_req (~22*HALF_CYC + gap); host inhibit stalls TX, aborted bytes are redone.
module ps2_dev_phy
    import ps2_dev_pkg::*;
#(
    parameter int HALF_CYC       = 4000,
    parameter int INTER_BYTE_CYC = 8000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clk_line,
    input  logic       dat_line,
    output logic       clk_low,
    output logic       dat_low,
    input  logic       tx_req,
    input  logic [7:0] tx_dat,
    output logic       tx_done,
    output logic       rx_vld,
    output logic [7:0] rx_dat,
    output logic       rx_perr,
    output logic       idle
);

    localparam int ACK_LEN = 2 * HALF_CYC + SYNC_STAGES + 1;
    localparam int MAXC    = (INTER_BYTE_CYC > ACK_LEN) ? INTER_BYTE_CYC : ACK_LEN;
    localparam int CW      = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HALF     = CW'(HALF_CYC);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] HALF_MID = CW'(HALF_CYC / 2);
    localparam logic [CW-1:0] PULSE    = CW'(2 * HALF_CYC);
    localparam logic [CW-1:0] ACK_M1   = CW'(ACK_LEN - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(INTER_BYTE_CYC - 1);
    localparam logic [CW-1:0] SETTLE   = CW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             bit_idx, bit_n;
    logic [10:0]            shf, shf_n;
    logic                   tx_done_n, rx_vld_n;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync <= '1;
            dat_sync <= '1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shf      <= '1;
            tx_done  <= 1'b0;
            rx_vld   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_line};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], dat_line};
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            shf      <= shf_n;
            tx_done  <= tx_done_n;
            rx_vld   <= rx_vld_n;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        shf_n     = shf;
        tx_done_n = 1'b0;
        rx_vld_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (!clk_s)
                    state_n = INHIBIT;
                else if (!dat_s)
                    state_n = RX_LOW;
                else if (tx_req) begin
                    state_n = TX_HIGH;
                    shf_n   = {1'b1, odd_par(tx_dat), tx_dat, 1'b0};
                end
            end
            INHIBIT: begin
                cnt_n = '0;
                if (clk_s)
                    state_n = IDLE;
            end
            // Host clock low is only trusted once our own release has propagated through the synchroniser.
            TX_HIGH: begin
                if (bit_idx != 4'd10 && cnt >= SETTLE && !clk_s) begin
                    state_n = INHIBIT;
                    cnt_n   = '0;
                end else if (cnt == HALF_M1) begin
                    state_n = TX_LOW;
                    cnt_n   = '0;
                end
            end
            TX_LOW: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd10) begin
                        state_n   = TX_GAP;
                        tx_done_n = 1'b1;
                    end else begin
                        state_n = TX_HIGH;
                        bit_n   = bit_idx + 1'b1;
                        shf_n   = {1'b1, shf[10:1]};
                    end
                end
            end
            TX_GAP: begin
                if (cnt == GAP_M1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            RX_LOW: begin
                if (cnt == HALF_M1) begin
                    state_n = RX_HIGH;
                    cnt_n   = '0;
                end
            end
            RX_HIGH: begin
                if (cnt == HALF_MID)
                    shf_n = {dat_s, shf[10:1]};
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd9) begin
                        state_n  = shf[10] ? RX_ACK : IDLE;
                        rx_vld_n = shf[10];
                    end else begin
                        state_n = RX_LOW;
                        bit_n   = bit_idx + 1'b1;
                    end
                end
            end
            // Tail of the ack lets the released data line settle so it is not mistaken for a new request.
            RX_ACK: begin
                if (cnt == ACK_M1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign clk_low = (state == TX_LOW) || (state == RX_LOW) || (state == RX_ACK && cnt < HALF);
    assign dat_low = ((state == TX_HIGH || state == TX_LOW) && !shf[0]) ||
                     (state == RX_ACK && cnt < PULSE);
    assign rx_dat  = shf[8:1];
    assign rx_perr = ~(^shf[9:1]);
    assign idle    = (state == IDLE);

endmodule

// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device: command decoder, 3-entry response queue, 3-byte movement packet buffer.
// Responses go out ahead of packets; MOVE_READY stays low until everything queued has been sent.
module ps2_mouse_device
    import ps2_dev_pkg::*;
#(
    parameter int HALF_CYC       = 4000,
    parameter int INTER_BYTE_CYC = 8000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire        CLK_MOUSE,
    inout  wire        DATA_MOUSE,
    input  logic       MOVE_VALID,
    output logic       MOVE_READY,
    input  logic [8:0] DX,
    input  logic [8:0] DY,
    input  logic [2:0] BUTTONS,
    output logic [7:0] CMD_BYTE,
    output logic       CMD_VALID,
    output logic       STREAMING
);

    logic       clk_low, dat_low, phy_idle;
    logic       tx_req, tx_done, rx_vld, rx_perr;
    logic [7:0] tx_dat, rx_dat;
    logic [7:0] resp_q [3];
    logic [7:0] pkt_q  [3];
    logic [1:0] resp_cnt, pkt_cnt;
    logic       bat_pend;
    logic       move_acc;

    ps2_dev_phy #(
        .HALF_CYC       (HALF_CYC),
        .INTER_BYTE_CYC (INTER_BYTE_CYC),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_phy (
        .CLK      (CLK),
        .RESET    (RESET),
        .clk_line (CLK_MOUSE),
        .dat_line (DATA_MOUSE),
        .clk_low  (clk_low),
        .dat_low  (dat_low),
        .tx_req   (tx_req),
        .tx_dat   (tx_dat),
        .tx_done  (tx_done),
        .rx_vld   (rx_vld),
        .rx_dat   (rx_dat),
        .rx_perr  (rx_perr),
        .idle     (phy_idle)
    );

    assign CLK_MOUSE  = clk_low ? 1'b0 : 1'bz;
    assign DATA_MOUSE = dat_low ? 1'b0 : 1'bz;

    assign tx_req     = (resp_cnt != 2'd0) || (pkt_cnt != 2'd0);
    assign tx_dat     = (resp_cnt != 2'd0) ? resp_q[0] : pkt_q[0];
    assign MOVE_READY = STREAMING && resp_cnt == 2'd0 && pkt_cnt == 2'd0 && phy_idle && !bat_pend;
    assign move_acc   = MOVE_VALID && MOVE_READY;

    // rx_vld, tx_done and move_acc are mutually exclusive by phy state, so one branch per cycle suffices.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            resp_q    <= '{default: 8'h00};
            pkt_q     <= '{default: 8'h00};
            resp_cnt  <= 2'd0;
            pkt_cnt   <= 2'd0;
            bat_pend  <= 1'b1;
            CMD_BYTE  <= 8'h00;
            CMD_VALID <= 1'b0;
            STREAMING <= 1'b0;
        end else begin
            CMD_VALID <= 1'b0;
            bat_pend  <= 1'b0;
            if (bat_pend) begin
                resp_q   <= '{BAT_OK, DEV_ID, 8'h00};
                resp_cnt <= 2'd2;
            end else if (rx_vld) begin
                pkt_cnt <= 2'd0;
                if (rx_perr) begin
                    resp_q[0] <= RESEND;
                    resp_cnt  <= 2'd1;
                end else begin
                    CMD_BYTE  <= rx_dat;
                    CMD_VALID <= 1'b1;
                    resp_q[0] <= ACK;
                    resp_cnt  <= 2'd1;
                    case (rx_dat)
                        CMD_RESET: begin
                            resp_q    <= '{ACK, BAT_OK, DEV_ID};
                            resp_cnt  <= 2'd3;
                            STREAMING <= 1'b0;
                        end
                        CMD_ENABLE:  STREAMING <= 1'b1;
                        CMD_DISABLE: STREAMING <= 1'b0;
                        CMD_GET_ID: begin
                            resp_q[1] <= DEV_ID;
                            resp_cnt  <= 2'd2;
                        end
                        default: ;
                    endcase
                end
            end else if (tx_done) begin
                if (resp_cnt != 2'd0) begin
                    resp_q[0] <= resp_q[1];
                    resp_q[1] <= resp_q[2];
                    resp_cnt  <= resp_cnt - 1'b1;
                end else if (pkt_cnt != 2'd0) begin
                    pkt_q[0] <= pkt_q[1];
                    pkt_q[1] <= pkt_q[2];
                    pkt_cnt  <= pkt_cnt - 1'b1;
                end
            end else if (move_acc) begin
                pkt_q   <= '{{2'b00, DY[8], DX[8], 1'b1, BUTTONS}, DX[7:0], DY[7:0]};
                pkt_cnt <= 2'd3;
            end
        end
    end

endmodule
